// File: rtl/dmawr2tlp_mch.sv
// DMA write packetizer: turns per-channel write requests plus 64-bit data streams
// into PCIe Memory Write TLPs (MAX_PAYLOAD and 4 KB aware), round-robin per TLP.
module dmawr2tlp_mch #(
  parameter int NCH         = 4,
  parameter int MAX_PAYLOAD = 256,
  parameter int BCNT_W      = 24
) (
  input  logic                  sclk,
  input  logic                  srst_n,
  input  logic [15:0]           cfg_req_id,
  input  logic [NCH-1:0]        req_valid,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH*64-1:0]     req_addr,
  input  logic [NCH*BCNT_W-1:0] req_bcount,
  input  logic [NCH-1:0]        dat_valid,
  output logic [NCH-1:0]        dat_ready,
  input  logic [NCH*64-1:0]     dat_data,
  output logic [NCH-1:0]        done,
  output logic                  tlp_valid,
  input  logic                  tlp_ready,
  output logic [63:0]           tlp_data,
  output logic                  tlp_sop,
  output logic                  tlp_eop,
  output logic [127:0]          tlp_hdr
);

  // Every interface here transfers on a cycle where valid and ready are both high;
  // valid never waits on ready, and the offered beat is held stable until taken.

  localparam int          CW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [12:0] MAX_PL = 13'(MAX_PAYLOAD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    XFER = 2'd2
  } state_t;

  state_t state;

  logic [63:0]       req_addr_a [NCH];
  logic [BCNT_W-1:0] req_bcnt_a [NCH];
  logic [63:0]       dat_data_a [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign req_addr_a[i] = req_addr[i*64 +: 64];
    assign req_bcnt_a[i] = req_bcount[i*BCNT_W +: BCNT_W];
    assign dat_data_a[i] = dat_data[i*64 +: 64];
  end

  logic [NCH-1:0]    ctx_active;
  logic [63:0]       ctx_addr [NCH];
  logic [BCNT_W-1:0] ctx_rem  [NCH];

  logic [CW-1:0]  gnt;
  logic [CW-1:0]  arb_sel;
  logic           arb_found;
  logic [12:0]    size_q;
  logic [9:0]     beat_cnt;
  logic           first_q;
  logic [127:0]   hdr_q;

  logic [NCH-1:0] hs;
  logic [NCH-1:0] active_nxt;
  logic [NCH-1:0] done_nxt;
  logic           xfer;
  logic           last_beat;
  logic           beat_acc;
  logic           eop_acc;
  logic           ctx_fin;

  assign hs        = req_valid & req_ready;
  assign xfer      = (state == XFER);
  assign last_beat = (beat_cnt == 10'd1);
  assign beat_acc  = tlp_valid & tlp_ready;
  assign eop_acc   = beat_acc & last_beat;
  assign ctx_fin   = eop_acc & (ctx_rem[gnt] == BCNT_W'(size_q));

  // Round-robin: search starts at the channel after the one granted last.
  always_comb begin
    int idx;
    arb_sel   = gnt;
    arb_found = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      idx = int'(gnt) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!arb_found && ctx_active[CW'(idx)]) begin
        arb_sel   = CW'(idx);
        arb_found = 1'b1;
      end
    end
  end

  logic [63:0]       sel_addr;
  logic [BCNT_W-1:0] sel_rem;
  logic [12:0]       bnd_room;
  logic [12:0]       lim;
  logic [12:0]       arb_size;
  logic              is4dw;
  logic [31:0]       dw0, dw1, dw2, dw3;

  assign sel_addr = ctx_addr[arb_sel];
  assign sel_rem  = ctx_rem[arb_sel];
  assign bnd_room = 13'h1000 - {1'b0, sel_addr[11:0]};
  assign lim      = (bnd_room < MAX_PL) ? bnd_room : MAX_PL;
  assign arb_size = (32'(sel_rem) < 32'(lim)) ? 13'(sel_rem) : lim;
  assign is4dw    = |sel_addr[63:32];

  // A 4096-byte TLP has length bit 10 set, which falls off the 10-bit field as 0.
  assign dw0 = {2'b01, is4dw, 5'b00000, 8'h00, 6'b000000, arb_size[11:2]};
  assign dw1 = {cfg_req_id, 8'h00, 4'hF, 4'hF};
  assign dw2 = is4dw ? sel_addr[63:32] : sel_addr[31:0];
  assign dw3 = is4dw ? sel_addr[31:0]  : 32'h0;

  always_comb begin
    active_nxt = ctx_active;
    done_nxt   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (hs[i]) begin
        if (req_bcnt_a[i] == '0) done_nxt[i]   = 1'b1;
        else                     active_nxt[i] = 1'b1;
      end
    end
    if (ctx_fin) begin
      active_nxt[gnt] = 1'b0;
      done_nxt[gnt]   = 1'b1;
    end
  end

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      state      <= IDLE;
      ctx_active <= '0;
      req_ready  <= '0;
      done       <= '0;
      gnt        <= CW'(NCH - 1);
      size_q     <= '0;
      beat_cnt   <= '0;
      first_q    <= 1'b0;
      hdr_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        ctx_addr[i] <= '0;
        ctx_rem[i]  <= '0;
      end
    end else begin
      ctx_active <= active_nxt;
      req_ready  <= ~active_nxt;
      done       <= done_nxt;
      for (int i = 0; i < NCH; i++) begin
        if (hs[i]) begin
          ctx_addr[i] <= req_addr_a[i];
          ctx_rem[i]  <= req_bcnt_a[i];
        end
      end
      if (eop_acc) begin
        ctx_addr[gnt] <= ctx_addr[gnt] + 64'(size_q);
        ctx_rem[gnt]  <= ctx_rem[gnt] - BCNT_W'(size_q);
      end
      case (state)
        IDLE: begin
          if (|ctx_active) state <= ARB;
        end
        ARB: begin
          if (arb_found) begin
            gnt      <= arb_sel;
            size_q   <= arb_size;
            beat_cnt <= arb_size[12:3];
            first_q  <= 1'b1;
            hdr_q    <= {dw3, dw2, dw1, dw0};
            state    <= XFER;
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          if (beat_acc) begin
            first_q  <= 1'b0;
            beat_cnt <= beat_cnt - 10'd1;
            if (last_beat) state <= (|active_nxt) ? ARB : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data path is a pure mux from the granted channel; a dat_valid gap just drops tlp_valid.
  assign tlp_valid = xfer & dat_valid[gnt];
  assign tlp_data  = xfer ? dat_data_a[gnt] : 64'h0;
  assign tlp_sop   = xfer & first_q;
  assign tlp_eop   = xfer & last_beat;
  assign tlp_hdr   = hdr_q;

  always_comb begin
    dat_ready = '0;
    if (xfer) dat_ready[gnt] = tlp_ready;
  end

endmodule

// File: doc/dmawr2tlp_mch.md
Name: dmawr2tlp_mch

Overview:
Multi-channel, parametrised DMA-write-to-PCIe-TLP packetizer. It accepts write requests (address, byte count) and 64-bit data streams from NCH DMA channels. Each request is split into Memory Write TLPs that respect MAX_PAYLOAD and 4 KB boundaries, and channels are interleaved round-robin per TLP onto one TLP stream toward the PCIe transmit interface. It sits between the DMA write engines and the PCIe core TX arbiter.

Parameters:
NCH, 4, number of DMA channels (1..8)
MAX_PAYLOAD, 256, max TLP payload in bytes; power of 2, 128..4096
BCNT_W, 24, width of request byte count

Ports:
sclk  in  1  system clock
srst_n  in  1  synchronous active-low reset
cfg_req_id  in  16  requester ID inserted in headers
req_valid  in  NCH  per-channel request valid
req_ready  out  NCH  per-channel request accepted (channel context free)
req_addr  in  NCH*64  per-channel start byte address, 8-byte aligned
req_bcount  in  NCH*BCNT_W  per-channel byte count, multiple of 8
dat_valid  in  NCH  per-channel data valid
dat_ready  out  NCH  per-channel data pop
dat_data  in  NCH*64  per-channel data; lower address in bits [31:0]
done  out  NCH  one-cycle pulse when a request's last beat is accepted
tlp_valid  out  1  TLP beat valid
tlp_ready  in  1  TLP sink ready
tlp_data  out  64  payload beat (2 DW)
tlp_sop  out  1  first beat of TLP; tlp_hdr valid only when set
tlp_eop  out  1  last beat of TLP
tlp_hdr  out  128  header DW0..DW3, DW0 in [31:0]

Behaviour:
- Reset: all contexts invalid; req_ready = all ones one cycle after srst_n deasserts. All other outputs 0. FSM in IDLE. Reset mid-TLP abandons the packet immediately; no eop is emitted.
- Context per channel: active flag, current address (64b), remaining bytes (BCNT_W). On req_valid & req_ready: load addr/bcount, and req_ready drops on the next cycle.
- bcount = 0: accepted, done pulses on the next cycle, no TLP is generated, and the context returns to free.
- TLP size = min(remaining, MAX_PAYLOAD, 4096 - addr[11:0]). It is always a multiple of 8, and beats = size/8.
- Header: 3DW (fmt=3'b010) if addr[63:32]==0, else 4DW (fmt=3'b011). Type = 5'b00000, TC/attr/TD/EP = 0, length = size/4 with 1024 DW encoded as 0. Bytes 4-7 of the header are requester ID, tag 8'h00, last BE 4'hF, first BE 4'hF. The address goes in DW2 (3DW) or in DW2 high / DW3 low (4DW). Unused DW3 = 0.
- FSM states:
  - IDLE: if any context is active, go to ARB.
  - ARB: 1 cycle. Round-robin grant among active contexts, starting after the last granted channel. Latch the header and beat count, then go to XFER.
  - XFER: tlp_valid = dat_valid[g]; dat_ready[g] = tlp_ready; data passes through combinationally. Beat counter decrements on each tlp_valid & tlp_ready.
    - On the eop beat accepted: addr += size and remaining -= size.
    - If remaining hits 0: clear the context, pulse done[g] on the next cycle, and allow req_ready[g] again on the next cycle.
    - Next state is ARB if any context is active (including newly loaded ones), else IDLE.
- Grant is held for the whole TLP; re-arbitration happens only between TLPs.
- Latency: first tlp_valid occurs at least 2 cycles after the req handshake (load, ARB), given dat_valid.
- tlp_sop = first beat of XFER. tlp_eop = beat counter == 1. A single-beat TLP has both sop and eop set.
- tlp_valid holds with stable data/hdr/sop/eop while tlp_ready = 0. A dat_valid gap deasserts tlp_valid without any state change.
- A request arriving on a channel while other channels transfer is loaded without disturbing the in-flight TLP.

Test Plan:
- Ch0 addr 0x0000_1000, bcount 64, MAX_PAYLOAD 256 → one 3DW TLP, length 16, 8 beats, sop on beat 1, eop on beat 8, done[0] pulse once.
- Ch1 addr 0x0000_0F80, bcount 512 → TLPs of 128 B (to 0x1000), 256 B, 128 B; addresses 0x0F80, 0x1000, 0x1100; done after the third TLP.
- Ch2 addr 0x1_0000_0000, bcount 8 → 4DW header: DW0 fmt 011, length 2; DW2 = 0x1, DW3 = 0x0; single beat with sop = eop = 1.
- Ch0 and ch3 each request 512 B at the same cycle → TLPs interleave 0,3,0,3; each done fires exactly once.
- tlp_ready toggled 1010… plus dat_valid gaps during a TLP → no beats lost or duplicated; outputs stable while stalled.
- bcount 0 on ch1 → done[1] one cycle later, no tlp_valid. Assert srst_n = 0 mid-TLP → tlp_valid = 0 next cycle, all req_ready = 1 after release.
